sample_delay_line: RTL

SAMPLE_DELAY_LINE -- requirements
Module: sample_delay_line

---
 rtl/sample_delay_line_if.sv | 43 ++++
 rtl/sample_delay_line.sv | 127 ++++++++++++
 2 files changed

// File: rtl/sample_delay_line_if.sv
// Sample delay line bus: control inputs, sample stream in, delayed
// stream and status out. The master drives samples and controls, the
// slave (the delay line) returns the delayed stream and fill status.
interface sample_delay_line_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 7
);

  logic [DEPTH_LOG2-1:0] delay_ctl;
  logic                  bypass;
  logic                  flush;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_in_valid;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic [DEPTH_LOG2:0]   fill_level;
  logic                  delay_active;

  modport master (
    output delay_ctl,
    output bypass,
    output flush,
    output data_in,
    output data_in_valid,
    input  data_out,
    input  data_out_valid,
    input  fill_level,
    input  delay_active
  );

  modport slave (
    input  delay_ctl,
    input  bypass,
    input  flush,
    input  data_in,
    input  data_in_valid,
    output data_out,
    output data_out_valid,
    output fill_level,
    output delay_active
  );

endinterface

// File: rtl/sample_delay_line.sv
// Programmable sample delay line. Samples are written into a circular
// buffer; once enough samples have been collected after a (re)fill, each
// new sample produces the sample written delay_lat samples earlier.
// A settle period follows reset, and any change of the requested delay
// or a flush pulse discards the history and starts a new fill.
module sample_delay_line #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 7,
  parameter int RESET_WAIT = 8
) (
  input logic               clk,
  input logic               rst,
  sample_delay_line_if.slave bus
);

  localparam int         DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [7:0] SETTLE_LAST = 8'(RESET_WAIT - 1);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                state;
  logic [7:0]            settle_cnt;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [DEPTH_LOG2-1:0] delay_lat;
  logic [DEPTH_LOG2:0]   fill_cnt;
  logic [DEPTH_LOG2:0]   fill_next;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] out_q;
  logic                  out_valid_q;
  logic                  active_q;
  logic                  refill;
  logic                  write_en;
  logic                  fill_at_lat;
  logic                  fill_next_at_lat;

  // The read address trails the write pointer by the latched delay, so for
  // any non-zero delay it can never equal the slot being written this cycle.
  assign rd_addr          = wr_ptr - delay_lat;
  assign rd_data          = mem[rd_addr];
  assign fill_next        = fill_cnt + 1'b1;
  assign fill_at_lat      = (fill_cnt == {1'b0, delay_lat});
  assign fill_next_at_lat = (fill_next == {1'b0, delay_lat});

  // A new delay request or a flush restarts the fill; the sample arriving in
  // that cycle is thrown away, so it must not reach the buffer either.
  assign refill   = (bus.delay_ctl != delay_lat) || bus.flush;
  assign write_en = (state != INIT) && !refill && bus.data_in_valid;

  assign bus.data_out       = out_q;
  assign bus.data_out_valid = out_valid_q;
  assign bus.fill_level     = fill_cnt;
  assign bus.delay_active   = active_q;

  // Sample storage; left unreset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // Control FSM with registered outputs: settle after reset, refill after
  // every delay change or flush, then stream delayed samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= INIT;
      settle_cnt  <= '0;
      wr_ptr      <= '0;
      fill_cnt    <= '0;
      delay_lat   <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (state == INIT) begin
        if (settle_cnt == SETTLE_LAST) begin
          state     <= FILL;
          delay_lat <= bus.delay_ctl;
          fill_cnt  <= '0;
        end else begin
          settle_cnt <= settle_cnt + 8'd1;
        end
      end else begin
        if (write_en) begin
          wr_ptr <= wr_ptr + 1'b1;
        end

        if (refill) begin
          delay_lat <= bus.delay_ctl;
          fill_cnt  <= '0;
          state     <= FILL;
          active_q  <= 1'b0;
        end else if (state == FILL) begin
          if (fill_at_lat) begin
            state    <= RUN;
            active_q <= 1'b1;
          end else if (bus.data_in_valid) begin
            fill_cnt <= fill_next;
            if (fill_next_at_lat) begin
              state    <= RUN;
              active_q <= 1'b1;
            end
          end
        end else if (bus.data_in_valid) begin
          out_valid_q <= 1'b1;
          out_q       <= (delay_lat == '0) ? bus.data_in : rd_data;
        end

        // Bypass only replaces what appears on the output; buffer writes and
        // state progression above carry on as if it were not set.
        if (bus.bypass) begin
          out_valid_q <= bus.data_in_valid;
          if (bus.data_in_valid) begin
            out_q <= bus.data_in;
          end
        end
      end
    end
  end

endmodule
